// File: rtl/omsp_dadd_seq.sv
// Sequential packed-BCD adder: one shared 4-bit decimal digit slice, LSB digit first.
// Latches operands on start, chains the digit carry, then reports result, C/Z/N and a done pulse.
module omsp_dadd_seq #(
  parameter int NIBBLES = 4,
  localparam int DW = 4 * NIBBLES
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          byte_mode,
  input  logic          carry_in,
  input  logic [DW-1:0] op_src,
  input  logic [DW-1:0] op_dst,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n
);

  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   a_q, b_q;
  logic            byte_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last_idx;
  logic            last_digit;
  logic [3:0]      da, db;
  logic [4:0]      s_raw;
  logic            dig_carry;
  logic [3:0]      digit;
  logic [DW-1:0]   result_nxt;
  logic            z_nxt, n_nxt;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign last_idx   = byte_q ? IW'(1) : IW'(NIBBLES - 1);
  assign last_digit = (idx == last_idx);

  // Digit slice: decimal correction adds 6 when the raw sum exceeds 9.
  always_comb begin
    da = '0;
    db = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        da = a_q[4*i +: 4];
        db = b_q[4*i +: 4];
      end
    end
    s_raw     = {1'b0, da} + {1'b0, db} + {4'b0000, carry_q};
    dig_carry = (s_raw > 5'd9);
    digit     = dig_carry ? (s_raw[3:0] + 4'd6) : s_raw[3:0];
  end

  always_comb begin
    result_nxt = result;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) result_nxt[4*i +: 4] = digit;
    end
    z_nxt = byte_q ? (result_nxt[7:0] == 8'h00) : (result_nxt == '0);
    n_nxt = byte_q ? result_nxt[7] : result_nxt[DW-1];
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are loaded on the final digit edge so they are valid alongside done.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      byte_q  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= op_src;
            b_q     <= op_dst;
            byte_q  <= byte_mode;
            carry_q <= carry_in;
            idx     <= '0;
            result  <= '0;
          end
        end
        RUN: begin
          result  <= result_nxt;
          carry_q <= dig_carry;
          if (last_digit) begin
            flag_c <= dig_carry;
            flag_z <= z_nxt;
            flag_n <= n_nxt;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_dadd_seq.sv
// Directed-vector bench for omsp_dadd_seq with hand-computed BCD sums, latency and flag checks.
module tb_omsp_dadd_seq;

  localparam int NIBBLES = 4;
  localparam int DW = 4 * NIBBLES;

  logic          mclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_mode = 1'b0;
  logic          carry_in = 1'b0;
  logic [DW-1:0] op_src = '0;
  logic [DW-1:0] op_dst = '0;
  logic          busy, done;
  logic [DW-1:0] result;
  logic          flag_c, flag_z, flag_n;

  int checks = 0;
  int errors = 0;

  omsp_dadd_seq #(.NIBBLES(NIBBLES)) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .start     (start),
    .byte_mode (byte_mode),
    .carry_in  (carry_in),
    .op_src    (op_src),
    .op_dst    (op_dst),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; cycles counts edges from acceptance.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic bm, output int cycles);
    @(negedge mclk);
    op_src = a; op_dst = b; carry_in = cin; byte_mode = bm; start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    op_src = '1; op_dst = '1; carry_in = 1'b0; byte_mode = 1'b0;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(posedge mclk); #1;
      cycles++;
    end
  endtask

  task automatic vec(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic cin, input logic bm, input logic [DW-1:0] exp_res,
                     input logic [2:0] exp_czn, input int exp_lat);
    int cyc;
    run_op(a, b, cin, bm, cyc);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_czn"}, {flag_c, flag_z, flag_n}, exp_czn);
    @(posedge mclk); #1;
    check({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int cyc;
    int dcount;
    int first_e, second_e;
    logic [DW-1:0] seen;

    #12;
    check("rst_out", {busy, done, flag_c, flag_z, flag_n}, 5'b0);
    check("rst_res", result, 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1;

    vec("w1234", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 3'b000, 5);
    vec("w9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b110, 5);
    vec("b45",   16'hAA45, 16'hAA55, 1'b0, 1'b1, 16'h0000, 3'b110, 3);
    vec("cin1",  16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 3'b000, 5);
    vec("cinN",  16'h4999, 16'h4000, 1'b1, 1'b0, 16'h9000, 3'b001, 5);
    vec("nbcd",  16'h000F, 16'h000F, 1'b0, 1'b0, 16'h0014, 3'b000, 5);
    check("idle_hold", result, 16'h0014);

    // start pulsed mid-operation must be ignored
    @(negedge mclk);
    op_src = 16'h1111; op_dst = 16'h2222; carry_in = 1'b0; byte_mode = 1'b0; start = 1'b1;
    dcount = 0; seen = '0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge mclk); #1;
      if (e == 1) start = 1'b0;
      if (e == 2) begin op_src = 16'h5555; op_dst = 16'h5555; start = 1'b1; end
      if (e == 3) start = 1'b0;
      if (done) begin dcount++; seen = result; end
    end
    check("ign_done", dcount, 1);
    check("ign_res", seen, 16'h3333);
    check("ign_hold", result, 16'h3333);

    // start held high: back-to-back acceptance
    @(negedge mclk);
    op_src = 16'h0001; op_dst = 16'h0002; start = 1'b1;
    first_e = 0; second_e = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge mclk); #1;
      if (done) begin
        if (first_e == 0) first_e = e;
        else if (second_e == 0) begin second_e = e; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("b2b_first", first_e, 5);
    check("b2b_second", second_e, 11);
    check("b2b_res", result, 16'h0003);

    // reset in the third RUN cycle after leaving C/Z set
    vec("pre_rst", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b110, 5);
    @(negedge mclk);
    op_src = 16'h1234; op_dst = 16'h5678; start = 1'b1;
    @(posedge mclk); #1; start = 1'b0;
    @(posedge mclk); #1;
    @(posedge mclk); #3;
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_out", {busy, done, flag_c, flag_z, flag_n}, 5'b0);
    check("arst_res", result, 16'h0000);
    dcount = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge mclk); #1;
      if (done) dcount++;
    end
    check("arst_nodone", dcount, 0);
    @(negedge mclk);
    reset_n = 1'b1;
    vec("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 3'b000, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/omsp_dadd_seq.md
Name: omsp_dadd_seq

Overview:
- Sequential decimal-add (DADD) controller: produces a 16-bit or 8-bit packed-BCD sum using one shared 4-bit digit-adder slice, one nibble per cycle, LSB digit first.
- Sits beside the ALU and frees it from a wide parallel BCD adder.
- Latches operands on a start handshake, runs the per-digit add and decimal correction while chaining the carry, then presents result, C/Z/N flags and a one-cycle done pulse.

Parameters:
- NIBBLES, 4, digits processed in word mode. Must be ≥2 and even; byte mode always processes 2.
- DW, 4*NIBBLES, operand/result width (derived, not overridden).

Ports:
- mclk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- byte_mode  input  1  1 = 8-bit operation (low 2 digits only); sampled with start.
- carry_in  input  1  decimal carry into digit 0; sampled with start.
- op_src  input  DW  BCD operand A; sampled with start.
- op_dst  input  DW  BCD operand B; sampled with start.
- busy  output  1  high from the cycle after start acceptance until done deasserts.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  output  DW  BCD sum; held until the next accepted start.
- flag_c  output  1  decimal carry out of the last processed digit.
- flag_z  output  1  result (within active width) == 0.
- flag_n  output  1  MSB of active width (bit 7 in byte mode, bit DW-1 in word mode).

Behaviour:
- Reset values while reset_n=0, applied asynchronously: state=IDLE, busy=0, done=0, result=0, flags=0, digit index=0, internal carry=0, operand registers=0.
- Digit operation, combinational per cycle:
  - s = a + b + c, 5-bit.
  - If s > 9: s = s + 6 and carry = 1; else carry = 0.
  - Result digit = s[3:0].
  - Non-BCD input digits get the same rule with no error flag; e.g. 0xF+0xF+0 = 30 → digit 0x4, carry 1.
- States:
  - IDLE: busy=0. If start=1: latch operands, byte_mode and carry_in; clear result to 0; set idx=0; go to RUN. If start=0: stay.
  - RUN: busy=1.
    - Compute digit idx from the latched operands and the carry register.
    - Write result[4*idx+3:4*idx]; update the carry register.
    - If idx == last (1 in byte mode, NIBBLES-1 in word mode): go to DONE. Else idx++.
  - DONE: busy=1, done=1 for exactly one cycle. Flags update from the final result/carry in this cycle. Go to IDLE unconditionally.
- Latency: start accepted at edge T0; done high in the cycle after edge T0+(digits+1); word mode with NIBBLES=4 gives done 5 cycles after the start edge.
- Byte mode: result[DW-1:8] = 0; flag_z covers bits 7:0 only.
- start while busy=1 (RUN or DONE) is ignored entirely and is not queued. Operand inputs may change freely after acceptance.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE, giving back-to-back throughput of digits+2 cycles per operation.
- result and flags hold their last values in IDLE until the next acceptance. result clears at acceptance; flags do not change until DONE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the partial result is discarded; no done pulse.
- The carry register chains between digits only. carry_in is used solely for digit 0.

Test Plan:
- Word add 0x1234 + 0x5678, carry_in=0 → done 5 cycles after start; result=0x6912, C=0, Z=0, N=0.
- Word add 0x9999 + 0x0001, carry_in=0 → result=0x0000, C=1, Z=1, N=0.
- Byte add 0x45 + 0x55 with op upper bytes 0xAA, carry_in=0 → result=0x0000, C=1, Z=1; done 3 cycles after start.
- Carry-in chain: 0x0999 + 0x0000, carry_in=1 → result=0x1000, C=0. Also 0x4999 + 0x4000, carry_in=1 → result=0x9000, N=1.
- Pulse start again 2 cycles into a word op with different operands → ignored; first result is unchanged and exactly one done pulse occurs. With start held high, the second op is accepted the cycle after done.
- Assert reset_n=0 in the 3rd RUN cycle → busy, done, result and flags are 0 asynchronously. After release, a fresh 0x0001 + 0x0001 completes with result=0x0002.
